// File: rtl/sysbus_mem_responder.sv
// Sysbus line responder: 8-beat line reads and writes
// against a 64-bit word memory with one-cycle read latency.
module sysbus_mem_responder #(
  parameter int LATENCY = 4,
  parameter int BEATS   = 8,
  parameter int TAG_W   = 13
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             reqcyc,
  input  logic [63:0]      req,
  input  logic [TAG_W-1:0] reqtag,
  output logic             reqack,
  output logic             respcyc,
  output logic [63:0]      resp,
  output logic [TAG_W-1:0] resptag,
  input  logic             respack,
  output logic             mem_rd,
  output logic             mem_wr,
  output logic [63:0]      mem_addr,
  output logic [63:0]      mem_wdata,
  input  logic [63:0]      mem_rdata
);
  localparam logic [3:0] DEV_MEM = 4'b0001;

  typedef enum logic [2:0] {
    IDLE,
    ACK,
    RD_WAIT,
    RD_BURST,
    WR_DATA,
    WR_RESP
  } state_t;

  state_t           state;
  logic [63:6]      base;
  logic [TAG_W-1:0] tag;
  logic [2:0]       cnt;
  logic [3:0]       rd_cnt;
  logic             inflight;
  logic [1:0]       fcount;
  logic [63:0]      buf0;
  logic [63:0]      buf1;
  logic [7:0]       wcnt;
  logic             wr_q;
  logic [63:0]      wr_addr;
  logic [63:0]      wdata_q;

  logic        dev_mem;
  logic        tag_mem;
  logic        new_rd;
  logic        burst_rd;
  logic        issue;
  logic        pop;
  logic        pop_buf;
  logic        last;
  logic [2:0]  occ;
  logic [63:0] rd_addr;

  assign dev_mem = tag[TAG_W-2 -: 4] == DEV_MEM;
  assign tag_mem = tag[TAG_W-1] && dev_mem;
  assign last    = cnt == 3'(BEATS - 1);

  // Beat 0 is fetched straight off the request bus so that
  // even a zero-latency read has its data in time.
  assign new_rd = state == IDLE && reqcyc
               && reqtag[TAG_W-1]
               && reqtag[TAG_W-2 -: 4] == DEV_MEM;

  assign occ = {1'b0, fcount} + {2'b0, inflight};

  assign burst_rd = (state == ACK || state == RD_WAIT
                  || state == RD_BURST)
                 && tag_mem
                 && rd_cnt < 4'(BEATS)
                 && occ < 3'd2 + {2'b0, pop_buf};

  assign issue = !reset && (new_rd || burst_rd);

  assign rd_addr = state == IDLE
                 ? {req[63:6], 6'b0}
                 : {base, rd_cnt[2:0], 3'b0};

  assign respcyc = (state == RD_BURST
                    && (!tag_mem || fcount != 2'd0))
                || state == WR_RESP;

  assign pop     = state == RD_BURST && respcyc && respack;
  assign pop_buf = pop && tag_mem;

  assign resp = (state == RD_BURST && respcyc)
              ? (tag_mem ? buf0 : '1)
              : '0;

  assign resptag   = tag;
  assign reqack    = state == ACK;
  assign mem_rd    = issue;
  assign mem_wr    = wr_q;
  assign mem_wdata = wdata_q;
  assign mem_addr  = issue ? rd_addr
                   : (wr_q ? wr_addr : '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      base     <= '0;
      tag      <= '0;
      cnt      <= '0;
      rd_cnt   <= '0;
      inflight <= 1'b0;
      fcount   <= '0;
      buf0     <= '0;
      buf1     <= '0;
      wcnt     <= '0;
      wr_q     <= 1'b0;
      wr_addr  <= '0;
      wdata_q  <= '0;
    end else begin
      inflight <= issue;
      if (issue) rd_cnt <= rd_cnt + 4'd1;

      if (inflight && pop_buf) begin
        if (fcount == 2'd2) begin
          buf0 <= buf1;
          buf1 <= mem_rdata;
        end else begin
          buf0 <= mem_rdata;
        end
      end else if (inflight) begin
        if (fcount == 2'd0) buf0 <= mem_rdata;
        else buf1 <= mem_rdata;
        fcount <= fcount + 2'd1;
      end else if (pop_buf) begin
        buf0   <= buf1;
        fcount <= fcount - 2'd1;
      end

      wr_q <= 1'b0;

      unique case (state)
        IDLE: begin
          if (reqcyc) begin
            base  <= req[63:6];
            tag   <= reqtag;
            cnt   <= '0;
            state <= ACK;
          end
        end
        ACK: begin
          if (tag[TAG_W-1]) begin
            if (LATENCY == 0) begin
              state <= RD_BURST;
            end else begin
              state <= RD_WAIT;
              wcnt  <= 8'(LATENCY - 1);
            end
          end else begin
            state <= WR_DATA;
          end
        end
        RD_WAIT: begin
          if (wcnt == 8'd0) state <= RD_BURST;
          else wcnt <= wcnt - 8'd1;
        end
        RD_BURST: begin
          if (pop) begin
            cnt <= cnt + 3'd1;
            if (last) begin
              state  <= IDLE;
              rd_cnt <= '0;
            end
          end
        end
        WR_DATA: begin
          if (reqcyc) begin
            wr_q    <= dev_mem;
            wr_addr <= {base, cnt, 3'b0};
            wdata_q <= req;
            cnt     <= cnt + 3'd1;
            if (last) state <= WR_RESP;
          end
        end
        WR_RESP: begin
          if (respack) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
